// File: rtl/sd_bmp_pixel_packer.sv
// Turns the SD card byte stream of a 24-bit BMP file into RGB565 pixel writes.
// The header is checked and dropped, row padding is skipped, and rows are flipped to top-down order.
module sd_bmp_pixel_packer #(
    parameter int HEADER_BYTES = 54,
    parameter int IMG_W        = 1024,
    parameter int IMG_H        = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_frame_start,
    input  logic        sd_valid,
    input  logic [7:0]  sd_data,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic [10:0] pix_row,
    output logic [10:0] pix_col,
    output logic        frame_done,
    output logic        hdr_err
);

    localparam int PAD = (4 - (IMG_W * 3) % 4) % 4;
    localparam int HCW = (HEADER_BYTES > 2) ? $clog2(HEADER_BYTES) : 1;

    localparam logic [HCW-1:0] HDR_LAST = HCW'(HEADER_BYTES - 1);
    localparam logic [10:0]    COL_LAST = 11'(IMG_W - 1);
    localparam logic [10:0]    ROW_LAST = 11'(IMG_H - 1);
    localparam logic [1:0]     PAD_LAST = (PAD > 0) ? 2'(PAD - 1) : 2'd0;

    localparam logic [7:0] SIG0 = 8'h42;
    localparam logic [7:0] SIG1 = 8'h4D;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PIX  = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]     r_state;
    logic [HCW-1:0] r_hdr_cnt;
    logic [1:0]     r_chan;
    logic [1:0]     r_pad_cnt;
    logic [10:0]    r_col;
    logic [10:0]    r_row;
    logic [7:0]     r_b;
    logic [7:0]     r_g;

    logic           r_sys_we;
    logic [15:0]    r_sys_data;
    logic [10:0]    r_pix_row;
    logic [10:0]    r_pix_col;
    logic           r_frame_done;
    logic           r_hdr_err;

    logic [15:0]    w_pix;
    logic           w_sig_bad;
    logic           w_row_end;
    logic           w_last_row;

    // The current byte is R, so the word can be built straight from the input.
    assign w_pix      = {sd_data[7:3], r_g[7:2], r_b[7:3]};
    assign w_sig_bad  = ((r_hdr_cnt == '0) && (sd_data != SIG0)) ||
                        ((r_hdr_cnt == HCW'(1)) && (sd_data != SIG1));
    assign w_row_end  = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hdr_cnt    <= '0;
            r_chan       <= 2'd0;
            r_pad_cnt    <= 2'd0;
            r_col        <= 11'd0;
            r_row        <= 11'd0;
            r_b          <= 8'd0;
            r_g          <= 8'd0;
            r_sys_we     <= 1'b0;
            r_sys_data   <= 16'd0;
            r_pix_row    <= 11'd0;
            r_pix_col    <= 11'd0;
            r_frame_done <= 1'b0;
            r_hdr_err    <= 1'b0;
        end else begin
            r_sys_we     <= 1'b0;
            r_frame_done <= 1'b0;
            if (sd_frame_start) begin
                // Abort whatever was in flight; a byte in this cycle is header byte 0.
                r_state   <= S_HDR;
                r_hdr_cnt <= '0;
                r_chan    <= 2'd0;
                r_pad_cnt <= 2'd0;
                r_col     <= 11'd0;
                r_row     <= 11'd0;
                r_hdr_err <= 1'b0;
                if (sd_valid) begin
                    if (sd_data != SIG0) begin
                        r_state   <= S_ERR;
                        r_hdr_err <= 1'b1;
                    end else begin
                        r_hdr_cnt <= HCW'(1);
                    end
                end
            end else if (sd_valid) begin
                case (r_state)
                    S_HDR: begin
                        if (w_sig_bad) begin
                            r_state   <= S_ERR;
                            r_hdr_err <= 1'b1;
                        end else if (r_hdr_cnt == HDR_LAST) begin
                            r_state <= S_PIX;
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + HCW'(1);
                        end
                    end
                    S_PIX: begin
                        case (r_chan)
                            2'd0: begin
                                r_b    <= sd_data;
                                r_chan <= 2'd1;
                            end
                            2'd1: begin
                                r_g    <= sd_data;
                                r_chan <= 2'd2;
                            end
                            default: begin
                                r_chan     <= 2'd0;
                                r_sys_we   <= 1'b1;
                                r_sys_data <= w_pix;
                                r_pix_col  <= r_col;
                                r_pix_row  <= ROW_LAST - r_row;
                                if (w_row_end) begin
                                    r_col <= 11'd0;
                                    r_row <= r_row + 11'd1;
                                    // The last row's padding is never waited for.
                                    if (w_last_row) begin
                                        r_state      <= S_DONE;
                                        r_frame_done <= 1'b1;
                                    end else if (PAD > 0) begin
                                        r_state   <= S_PAD;
                                        r_pad_cnt <= 2'd0;
                                    end
                                end else begin
                                    r_col <= r_col + 11'd1;
                                end
                            end
                        endcase
                    end
                    S_PAD: begin
                        if (r_pad_cnt == PAD_LAST) begin
                            r_state   <= S_PIX;
                            r_pad_cnt <= 2'd0;
                        end else begin
                            r_pad_cnt <= r_pad_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sys_we      = r_sys_we;
    assign sys_data_in = r_sys_data;
    assign pix_row     = r_pix_row;
    assign pix_col     = r_pix_col;
    assign frame_done  = r_frame_done;
    assign hdr_err     = r_hdr_err;

endmodule

// File: doc/sd_bmp_pixel_packer.md
# sd_bmp_pixel_packer

Converts the raw byte stream read from the SD card into 16-bit RGB565 pixel writes for the SDRAM/VGA frame path. It parses and discards the 54-byte BMP file header, checks the "BM" signature, and assembles each 24-bit BGR triplet into one RGB565 word. It also strips the per-row 4-byte alignment padding and tags each pixel with its display row and column. It sits between the SD SPI reader and the `sys_we`/`sys_data_in` write port of `sdram_vga_top`, in the `clk_ref` domain.

## Interface
Parameters:
- `HEADER_BYTES`, 54, BMP header length in bytes; bytes 0 and 1 are the signature.
- `IMG_W`, 1024, image width in pixels.
- `IMG_H`, 768, image height in pixels.
- `PAD`, derived as (4 - (IMG_W*3) mod 4) mod 4, padding bytes at the end of each BMP row; 0 for the default width.

Ports:
- `clk`  in  1  SDRAM controller clock (`clk_ref`); single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sd_frame_start`  in  1  one-cycle pulse marking byte 0 of a new file.
- `sd_valid`  in  1  `sd_data` is valid this cycle; may be asserted on consecutive cycles.
- `sd_data`  in  8  file byte.
- `sys_we`  out  1  one-cycle pixel write strobe.
- `sys_data_in`  out  16  pixel, laid out as {R[7:3], G[7:2], B[7:3]}.
- `pix_row`  out  11  display row of the current pixel; 0 is the top row.
- `pix_col`  out  11  display column of the current pixel.
- `frame_done`  out  1  one-cycle pulse after the last pixel is written.
- `hdr_err`  out  1  level; set on a signature mismatch, cleared by `rst` or `sd_frame_start`.

## Operation
- States are IDLE, HDR, PIX, PAD, DONE and ERR. Only a cycle with `sd_valid`=1 consumes a byte.
- IDLE to HDR on `sd_frame_start`.
  - If `sd_valid` is also high in that same cycle, the byte is header byte 0.
  - HDR clears the byte, channel, column and row counters.
- HDR checks the signature: byte 0 must be 0x42 and byte 1 must be 0x4D.
  - On a mismatch, go to ERR and set `hdr_err`.
  - The remaining header bytes are counted and discarded. After byte `HEADER_BYTES`-1, go to PIX.
- PIX uses a channel counter cycling 0, 1, 2 for B, G and R, latching B and G.
  - On the R byte, register the pixel and drive `sys_we`.
  - `pix_col` counts from 0 to `IMG_W`-1.
  - `pix_row` = `IMG_H`-1-`bmp_row`, because BMP stores rows bottom-up. `bmp_row` starts at 0.
- At the end of a row (col = `IMG_W`-1):
  - If `PAD`>0, go to PAD, discard `PAD` bytes, then return to PIX.
  - If `PAD`=0, stay in PIX.
  - In either case, col wraps to 0 and `bmp_row` increments.
- After the last pixel (`bmp_row`=`IMG_H`-1, col=`IMG_W`-1), go to DONE and pulse `frame_done`. The final row's padding is not awaited.
- DONE and ERR ignore all bytes. Only `sd_frame_start` or `rst` leaves them; both go to HDR (or IDLE for `rst`).
- `sd_frame_start` in any state aborts the current frame. It restarts HDR with counters cleared and `hdr_err` cleared. No partial pixel is emitted.
- Width rules:
  - Counters are sized for 2048 columns and rows.
  - The header counter must hold `HEADER_BYTES`-1.
  - Truncation to 565 takes the most significant bits only; no rounding.

## Timing
- Reset values: `sys_we`=0, `sys_data_in`=0, `pix_row`=0, `pix_col`=0, `frame_done`=0, `hdr_err`=0, state IDLE.
- Latency: `sys_we` and `sys_data_in` are registered. They are valid exactly 1 cycle after the cycle in which the R byte is accepted.
  - `pix_row` and `pix_col` are valid in the same cycle as `sys_we`.
- `sys_we` is high for exactly 1 cycle per pixel. Back-to-back bytes give at most 1 write every 3 cycles.
- `frame_done` is asserted in the same cycle as the last `sys_we`.
- `hdr_err` rises 1 cycle after the mismatching signature byte is accepted.
- There is no backpressure. The downstream FIFO must accept any `sys_we`.
- `rst` has priority over `sd_frame_start`, and both have priority over `sd_valid`.

## Test plan
- Valid header with `IMG_W`=4, `IMG_H`=2, `PAD`=0, and 24 pixel bytes where pixel 0 is B=0xFF, G=0x00, R=0x00 -> the first `sys_we` carries 0x001F with row 1, col 0.
  - 8 writes in total, then `frame_done` together with the 8th write, on row 0, col 3.
- `IMG_W`=3 (`PAD`=3) with padding bytes set to 0xAA -> exactly 6 writes with no 0xAA-derived word, and cols follow 0,1,2,0,1,2.
- Header starting 0x42 0x4E -> `hdr_err`=1 one cycle later, with no `sys_we` for the rest of the file. A new `sd_frame_start` followed by a valid header clears `hdr_err` and produces normal writes.
- Bytes with gaps (`sd_valid` toggling) versus back-to-back bytes -> identical pixel values and identical count. In the back-to-back case each `sys_we` comes 1 cycle after its R byte.
- `sd_frame_start` after 5 pixels of a frame -> no further writes from the old frame, and the counters restart: the next write is row `IMG_H`-1, col 0.
- `rst` asserted mid-PIX for 1 cycle -> all outputs 0 on the next cycle and state IDLE. Bytes are ignored until `sd_frame_start`.
